// File: rtl/aes_key_expand.sv
// AES-128 key expansion: emits round keys 0..10 one per ready/valid handshake.
// The S-box is computed as GF(2^8) inversion followed by the FIPS-197 affine map.
module aes_key_expand (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [3:0]   rk_round,
    output logic [127:0] rk_out,
    output logic         busy,
    output logic         done
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [127:0] r_key;
    logic [3:0]   r_round;
    logic         r_valid;
    logic         r_busy;
    logic         r_done;
    logic [7:0]   r_rcon;

    logic         w_accept;
    logic         w_hs;
    logic         w_last;
    logic [31:0]  w_rot;
    logic [31:0]  w_t;
    logic [31:0]  w_n0;
    logic [31:0]  w_n1;
    logic [31:0]  w_n2;
    logic [31:0]  w_n3;
    logic [127:0] w_next_key;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 == x^-1 in GF(2^8), and maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] y;
        logic [7:0] r;
        y = gf_mul(a, a);
        r = y;
        for (int unsigned i = 0; i < 6; i++) begin
            y = gf_mul(y, y);
            r = gf_mul(r, y);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    always_comb begin
        w_accept = (r_state == IDLE) && start;
        w_hs     = (r_state == EMIT) && r_valid && rk_ready;
        w_last   = w_hs && (r_round == 4'd10);
    end

    always_comb begin
        w_rot      = {r_key[23:0], r_key[31:24]};
        w_t        = sub_word(w_rot) ^ {r_rcon, 24'h0};
        w_n0       = r_key[127:96] ^ w_t;
        w_n1       = r_key[95:64]  ^ w_n0;
        w_n2       = r_key[63:32]  ^ w_n1;
        w_n3       = r_key[31:0]   ^ w_n2;
        w_next_key = {w_n0, w_n1, w_n2, w_n3};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_next = EMIT;
            EMIT:    if (w_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key   <= '0;
            r_round <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rcon  <= 8'h01;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_key   <= key_in;
                r_round <= '0;
                r_valid <= 1'b1;
                r_busy  <= 1'b1;
                r_rcon  <= 8'h01;
            end else if (w_last) begin
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
            end else if (w_hs) begin
                r_key   <= w_next_key;
                r_round <= r_round + 4'd1;
                r_rcon  <= xtime(r_rcon);
            end
        end
    end

    always_comb begin
        rk_valid = r_valid;
        rk_round = r_round;
        rk_out   = r_key;
        busy     = r_busy;
        done     = r_done;
    end

endmodule
